// File: rtl/ks_adder_pipe.sv
// Parametrised Kogge-Stone adder/subtractor. Optional register after pre-processing
// and after every prefix level; valid, tag and a global stall travel with the data.
module ks_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1,
  parameter int TAG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_sub,
  input  logic             i_c0,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic [TAG_W-1:0] o_tag
);

  localparam int L = $clog2(WIDTH);

  // Position 0 of every prefix vector is the carry-in (g = cin, p = 0); position j is bit j-1.
  function automatic logic [WIDTH:0] ks_g(input logic [WIDTH:0] g, input logic [WIDTH:0] p,
                                          input int k);
    logic [WIDTH:0] r;
    int d;
    d = 32'sd1 << k;
    r = g;
    for (int j = 0; j <= WIDTH; j++) begin
      if (j >= d) begin
        r[j] = g[j] | (p[j] & g[j - d]);
      end else begin
        r[j] = g[j];
      end
    end
    return r;
  endfunction

  function automatic logic [WIDTH:0] ks_p(input logic [WIDTH:0] p, input int k);
    logic [WIDTH:0] r;
    int d;
    d = 32'sd1 << k;
    r = p;
    for (int j = 0; j <= WIDTH; j++) begin
      if (j >= d) begin
        r[j] = p[j] & p[j - d];
      end else begin
        r[j] = p[j];
      end
    end
    return r;
  endfunction

  logic [WIDTH-1:0] b_inv_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic             cin_s;
  logic [WIDTH:0]   pre_g_s;
  logic [WIDTH:0]   pre_p_s;

  logic             fin_vld_s;
  logic [TAG_W-1:0] fin_tag_s;
  logic [WIDTH-1:0] fin_ps_s;
  logic [WIDTH:0]   fin_g_s;

  // Pre-processing: operand inversion for subtract, bitwise p/g, carry-in folded into bit 0.
  always_comb begin
    b_inv_s    = i_b ^ {WIDTH{i_sub}};
    cin_s      = i_c0 ^ i_sub;
    p_s        = i_a ^ b_inv_s;
    g_s        = i_a & b_inv_s;
    pre_p_s    = {p_s, 1'b0};
    pre_g_s    = {g_s, cin_s};
    pre_g_s[1] = g_s[0] | (p_s[0] & cin_s);
  end

  if (PIPE != 0) begin : g_pipe
    logic [L:0]              vld_r;
    logic [L:0][TAG_W-1:0]   tag_r;
    logic [L:0][WIDTH-1:0]   ps_r;
    logic [L:0][WIDTH:0]     g_r;
    logic [L-1:0][WIDTH:0]   p_r;
    logic [L:0][WIDTH:0]     g_nxt_s;
    logic [L-1:0][WIDTH:0]   p_nxt_s;

    // Each prefix level is evaluated from the register of the level before it.
    always_comb begin
      g_nxt_s[0] = pre_g_s;
      p_nxt_s[0] = pre_p_s;
      for (int k = 1; k <= L; k++) begin
        g_nxt_s[k] = ks_g(g_r[k-1], p_r[k-1], k - 1);
      end
      for (int k = 1; k < L; k++) begin
        p_nxt_s[k] = ks_p(p_r[k-1], k - 1);
      end
    end

    // Stage registers: reset clears everything, stall freezes every stage together.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        vld_r <= {(L + 1){1'b0}};
        tag_r <= {((L + 1) * TAG_W){1'b0}};
        ps_r  <= {((L + 1) * WIDTH){1'b0}};
        g_r   <= {((L + 1) * (WIDTH + 1)){1'b0}};
        p_r   <= {(L * (WIDTH + 1)){1'b0}};
      end else if (!i_stall) begin
        vld_r <= {vld_r[L-1:0], i_valid};
        tag_r <= {tag_r[L-1:0], i_tag};
        ps_r  <= {ps_r[L-1:0], p_s};
        g_r   <= g_nxt_s;
        p_r   <= p_nxt_s;
      end
    end

    assign fin_vld_s = vld_r[L];
    assign fin_tag_s = tag_r[L];
    assign fin_ps_s  = ps_r[L];
    assign fin_g_s   = g_r[L];
  end else begin : g_comb
    logic [L:0][WIDTH:0]   g_c_s;
    logic [L-1:0][WIDTH:0] p_c_s;

    // Whole prefix tree in one cycle; the propagate chain is built first.
    always_comb begin
      p_c_s[0] = pre_p_s;
      for (int k = 1; k < L; k++) begin
        p_c_s[k] = ks_p(p_c_s[k-1], k - 1);
      end
      g_c_s[0] = pre_g_s;
      for (int k = 1; k <= L; k++) begin
        g_c_s[k] = ks_g(g_c_s[k-1], p_c_s[k-1], k - 1);
      end
    end

    assign fin_vld_s = i_valid;
    assign fin_tag_s = i_tag;
    assign fin_ps_s  = p_s;
    assign fin_g_s   = g_c_s[L];
  end

  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;
  logic             valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic [TAG_W-1:0] out_tag_r;

  // Sum from the saved propagate and the group carries; overflow is carry-in(MSB) ^ carry-out.
  always_comb begin
    sum_s  = fin_ps_s ^ fin_g_s[WIDTH-1:0];
    cout_s = fin_g_s[WIDTH];
    ovf_s  = fin_g_s[WIDTH] ^ fin_g_s[WIDTH-1];
  end

  // Output register; result fields are zero whenever the result is not valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_r   <= 1'b0;
      sum_r     <= {WIDTH{1'b0}};
      cout_r    <= 1'b0;
      ovf_r     <= 1'b0;
      out_tag_r <= {TAG_W{1'b0}};
    end else if (!i_stall) begin
      valid_r <= fin_vld_s;
      if (fin_vld_s) begin
        sum_r     <= sum_s;
        cout_r    <= cout_s;
        ovf_r     <= ovf_s;
        out_tag_r <= fin_tag_s;
      end else begin
        sum_r     <= {WIDTH{1'b0}};
        cout_r    <= 1'b0;
        ovf_r     <= 1'b0;
        out_tag_r <= {TAG_W{1'b0}};
      end
    end
  end

  assign o_valid = valid_r;
  assign o_sum   = sum_r;
  assign o_cout  = cout_r;
  assign o_ovf   = ovf_r;
  assign o_tag   = out_tag_r;

endmodule

// File: doc/ks_adder_pipe.md
# ks_adder_pipe

Parametrised, pipelined Kogge-Stone adder/subtractor for the FFT datapath butterflies. It generalises the fixed 32-bit, single-level prefix stages to any power-of-two width and builds the full prefix tree internally. An optional register sits after every prefix level. A valid bit, a sideband tag and a global stall travel with each operand pair.

## Interface
- WIDTH, 32, operand width; power of two, 4..64
- PIPE, 1, 1 = register after pre-processing, after every prefix level and at the output; 0 = combinational tree with output register only
- TAG_W, 8, sideband tag width carried alongside data
- i_clk  input  1  clock, all logic on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_valid  input  1  operand pair valid this cycle
- i_stall  input  1  freeze entire pipeline (no stage advances)
- i_sub  input  1  0 = A+B+c0, 1 = A-B (B inverted, carry-in inverted)
- i_c0  input  1  carry-in
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B
- i_tag  input  TAG_W  sideband, returned unchanged with result
- o_valid  output  1  result valid
- o_sum  output  WIDTH  sum/difference
- o_cout  output  1  carry-out of MSB
- o_ovf  output  1  two's-complement signed overflow
- o_tag  output  TAG_W  tag of the operand pair producing this result

## Operation
- Pre-process: b' = i_b ^ {WIDTH{i_sub}}; cin = i_c0 ^ i_sub; p = a ^ b', g = a & b'; p_save = p retained for sum.
- Carry-in injected as generate at position -1 (gkj[0] = cin), as in the grey-cell convention.
- Prefix levels k = 0..L-1, L = log2(WIDTH): span d = 2^k. Bit i ≥ d-1 uses a black cell, or a grey cell where the lower partner resolves the carry-in. Bits below span pass through.
- Sum: sum[i] = p_save[i] ^ G[i-1], with G[-1] = cin; cout = G[WIDTH-1]; ovf = carry into MSB ^ cout.
- Arithmetic modulo 2^WIDTH; no saturation.
- Valid, tag and p_save shift with data through every pipeline register.
- Bubbles (i_valid=0) propagate; data registers of invalid stages may take any value, but o_sum/o_cout/o_ovf/o_tag are forced to 0 when o_valid=0.

## Timing
- Latency PIPE=1: L+2 cycles (WIDTH=32: 7). PIPE=0: 1 cycle.
- Throughput one result per non-stalled cycle; no backpressure other than i_stall.
- i_stall=1: every register, including output, holds. i_valid/operands sampled that cycle are ignored. o_valid stays as held.
- Reset (i_rst_n=0 at a rising edge): all valid bits to 0. o_valid, o_sum, o_cout, o_ovf, o_tag = 0 next cycle. In-flight data is discarded. Reset overrides stall.
- First valid input after reset release appears exactly latency cycles later.
- Simultaneous stall and reset: reset wins. Stall with empty pipeline: no effect.

## Test plan
- WIDTH=32, PIPE=1: a=0xFFFF_FFFF, b=0x0000_0001, c0=0, sub=0, tag=0x5A -> 7 cycles later o_sum=0, o_cout=1, o_ovf=0, o_tag=0x5A, o_valid=1 for exactly one cycle.
- Signed overflow: a=0x7FFF_FFFF, b=1, add -> o_sum=0x8000_0000, o_ovf=1, o_cout=0. sub=1, a=0x8000_0000, b=1 -> o_sum=0x7FFF_FFFF, o_ovf=1, o_cout=1.
- Back-to-back stream of 100 random pairs with random sub/c0 and random bubbles -> results match reference model in order, tags intact, o_valid pattern equals input pattern delayed 7.
- Stall for 3 cycles while 4 results are in flight -> outputs frozen during stall, then all 4 emerge in order, none lost or duplicated.
- Assert i_rst_n=0 for one cycle mid-stream -> next cycle o_valid=0 and all outputs 0. No pre-reset result ever emerges. A new input issued 1 cycle after release returns 7 cycles later.
- Parameter sweep WIDTH=4,16,64 with PIPE=0 and 1 -> exhaustive (WIDTH=4) or 10k random checks pass, latency 1 or L+2 respectively.
